// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the integer register file write ports
// Grants up to NR_WB_PORTS same-cycle writes, never two to one register, and registers them onto the ports.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NR_SRC        = 4,
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter bit          ZERO_REG_ZERO = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [NR_SRC-1:0]                 src_valid_i,
  input  logic [NR_SRC*5-1:0]               src_waddr_i,
  input  logic [NR_SRC*DATA_WIDTH-1:0]      src_wdata_i,
  output logic [NR_SRC-1:0]                 src_ready_o,
  output logic [NR_WB_PORTS*5-1:0]          waddr_o,
  output logic [NR_WB_PORTS*DATA_WIDTH-1:0] wdata_o,
  output logic [NR_WB_PORTS-1:0]            we_o,
  output logic                              conflict_o
);

  localparam int unsigned RR_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

  logic [RR_W-1:0]                  rr_q, rr_d;
  logic [NR_WB_PORTS*5-1:0]          waddr_q;
  logic [NR_WB_PORTS*DATA_WIDTH-1:0] wdata_q;
  logic [NR_WB_PORTS-1:0]            we_q;
  logic                              conflict_q, conflict_d;

  logic [NR_SRC-1:0]      grant;
  logic [NR_WB_PORTS-1:0] port_vld;
  logic [4:0]             port_addr [NR_WB_PORTS];
  logic [DATA_WIDTH-1:0]  port_data [NR_WB_PORTS];

  // x0 is a sink when ZERO_REG_ZERO is set, so it can be written by many sources at once
  function automatic logic zero_exempt(input logic [4:0] a);
    return ZERO_REG_ZERO && (a == 5'd0);
  endfunction

  always_comb begin
    int unsigned n;
    int unsigned idx;
    logic        v;
    logic        hit;
    logic [4:0]  a;
    logic [DATA_WIDTH-1:0] d;

    grant      = '0;
    port_vld   = '0;
    conflict_d = 1'b0;
    rr_d       = rr_q;
    for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
      port_addr[k] = '0;
      port_data[k] = '0;
    end
    n   = 0;
    idx = 0;
    v   = 1'b0;
    hit = 1'b0;
    a   = '0;
    d   = '0;

    for (int unsigned i = 0; i < NR_SRC; i++) begin
      idx = (32'(rr_q) + i) % NR_SRC;
      v   = 1'b0;
      a   = '0;
      d   = '0;
      for (int unsigned s = 0; s < NR_SRC; s++) begin
        if (s == idx) begin
          v = src_valid_i[s];
          a = src_waddr_i[s*5 +: 5];
          d = src_wdata_i[s*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      hit = 1'b0;
      for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
        if (port_vld[k] && (port_addr[k] == a) && !zero_exempt(a)) hit = 1'b1;
      end

      // A conflict only counts while a port was still available for this source
      if (v && (n < NR_WB_PORTS)) begin
        if (hit) begin
          conflict_d = 1'b1;
        end else begin
          for (int unsigned s = 0; s < NR_SRC; s++) begin
            if (s == idx) grant[s] = 1'b1;
          end
          for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
            if (k == n) begin
              port_vld[k]  = 1'b1;
              port_addr[k] = a;
              port_data[k] = d;
            end
          end
          rr_d = RR_W'((idx + 1) % NR_SRC);
          n    = n + 1;
        end
      end
    end

    if (flush_i) begin
      grant      = '0;
      port_vld   = '0;
      conflict_d = 1'b0;
      rr_d       = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      we_q       <= '0;
      conflict_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      conflict_q <= conflict_d;
      // Idle ports keep their last address/data; only the enable drops
      for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
        we_q[k] <= port_vld[k] && !zero_exempt(port_addr[k]);
        if (port_vld[k]) begin
          waddr_q[k*5 +: 5]                   <= port_addr[k];
          wdata_q[k*DATA_WIDTH +: DATA_WIDTH] <= port_data[k];
        end
      end
    end
  end

  assign src_ready_o = grant;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign we_o        = we_q;
  assign conflict_o  = conflict_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - bench for regfile_wb_arbiter (4 sources, 2 ports, x0 sink on and off)
module tb_regfile_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         flush;
  logic [3:0]   sv;
  logic [19:0]  sa;
  logic [127:0] sd;

  logic [3:0]  rdy [2];
  logic [9:0]  wa  [2];
  logic [63:0] wd  [2];
  logic [1:0]  we  [2];
  logic        cf  [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .NR_SRC(4), .NR_WB_PORTS(2), .ZERO_REG_ZERO(1'b1)) dut_z (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .src_valid_i(sv), .src_waddr_i(sa), .src_wdata_i(sd),
    .src_ready_o(rdy[0]), .waddr_o(wa[0]), .wdata_o(wd[0]), .we_o(we[0]), .conflict_o(cf[0])
  );

  regfile_wb_arbiter #(.DATA_WIDTH(32), .NR_SRC(4), .NR_WB_PORTS(2), .ZERO_REG_ZERO(1'b0)) dut_n (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .src_valid_i(sv), .src_waddr_i(sa), .src_wdata_i(sd),
    .src_ready_o(rdy[1]), .waddr_o(wa[1]), .wdata_o(wd[1]), .we_o(we[1]), .conflict_o(cf[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk sources in priority order, take the first two that do not repeat a taken register
  function automatic void predict(input bit zrz, input int rr, input logic [3:0] v, input logic [19:0] ad,
                                  output int nwin, output int w0, output int w1, output bit conf);
    int order[$];
    logic [4:0] taken[$];
    nwin = 0; w0 = 0; w1 = 0; conf = 1'b0;
    for (int i = 0; i < 4; i++) order.push_back((rr + i) % 4);
    foreach (order[j]) begin
      int s;
      logic [4:0] a;
      bit dup;
      s = order[j];
      a = ad[s*5 +: 5];
      dup = 1'b0;
      if (v[s] && nwin < 2) begin
        foreach (taken[t]) if (taken[t] == a && !(zrz && a == 5'd0)) dup = 1'b1;
        if (dup) conf = 1'b1;
        else begin
          if (nwin == 0) w0 = s; else w1 = s;
          nwin++;
          taken.push_back(a);
        end
      end
    end
  endfunction

  int         m_rr   [2];
  logic [1:0] m_we   [2];
  logic [9:0] m_addr [2];
  logic [63:0] m_data [2];
  logic       m_conf [2];

  always @(negedge clk) begin
    int nwin, w0, w1, s;
    bit conf, zrz;
    logic [3:0] exp_rdy;
    logic [4:0] a;
    for (int d = 0; d < 2; d++) begin
      if (!rst_ni) begin
        chk($sformatf("rst_we%0d", d), 64'(we[d]), 64'(0));
        chk($sformatf("rst_conf%0d", d), 64'(cf[d]), 64'(0));
        chk($sformatf("rst_waddr%0d", d), 64'(wa[d]), 64'(0));
        chk($sformatf("rst_wdata%0d", d), wd[d], 64'(0));
        chk($sformatf("rst_ready%0d", d), 64'(rdy[d]), 64'(0));
        m_rr[d] = 0; m_we[d] = '0; m_addr[d] = '0; m_data[d] = '0; m_conf[d] = 1'b0;
      end else begin
        zrz = (d == 0);
        chk($sformatf("we%0d", d), 64'(we[d]), 64'(m_we[d]));
        chk($sformatf("waddr%0d", d), 64'(wa[d]), 64'(m_addr[d]));
        chk($sformatf("wdata%0d", d), wd[d], m_data[d]);
        chk($sformatf("conflict%0d", d), 64'(cf[d]), 64'(m_conf[d]));
        predict(zrz, m_rr[d], sv, sa, nwin, w0, w1, conf);
        exp_rdy = '0;
        if (!flush) begin
          if (nwin > 0) exp_rdy[w0] = 1'b1;
          if (nwin > 1) exp_rdy[w1] = 1'b1;
        end
        chk($sformatf("ready%0d", d), 64'(rdy[d]), 64'(exp_rdy));
        if (flush) begin
          m_we[d] = '0; m_rr[d] = 0; m_conf[d] = 1'b0;
        end else begin
          m_conf[d] = conf;
          m_we[d] = '0;
          for (int p = 0; p < nwin; p++) begin
            s = (p == 0) ? w0 : w1;
            a = sa[s*5 +: 5];
            m_addr[d][p*5 +: 5]  = a;
            m_data[d][p*32 +: 32] = sd[s*32 +: 32];
            m_we[d][p] = !(zrz && a == 5'd0);
          end
          if (nwin > 0) m_rr[d] = (((nwin == 1) ? w0 : w1) + 1) % 4;
        end
      end
    end
  end

  int cnt[4];
  logic [3:0] got;

  initial begin
    rst_ni = 1'b0; flush = 1'b0; sv = '0; sa = '0; sd = '0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    // four distinct writes, two per cycle
    sv = 4'b1111; sa = {5'd4, 5'd3, 5'd2, 5'd1};
    sd = {32'hdddd0003, 32'hcccc0002, 32'hbbbb0001, 32'haaaa0000};
    @(negedge clk); chk("t1_ready_c0", 64'(rdy[0]), 64'h3);
    @(posedge clk); #1 sv = 4'b1100;
    @(negedge clk);
    chk("t1_ready_c1", 64'(rdy[0]), 64'hc);
    chk("t1_waddr_c1", 64'(wa[0]), 64'({5'd2, 5'd1}));
    chk("t1_we_c1", 64'(we[0]), 64'h3);
    @(posedge clk); #1 sv = 4'b0000;
    @(negedge clk);
    chk("t1_waddr_c2", 64'(wa[0]), 64'({5'd4, 5'd3}));
    chk("t1_wdata_c2", wd[0], {32'hdddd0003, 32'hcccc0002});
    chk("t1_we_c2", 64'(we[0]), 64'h3);

    // same-address pair: the later one waits
    @(posedge clk); #1 sv = 4'b0111; sa = {5'd0, 5'd6, 5'd5, 5'd5};
    @(negedge clk); chk("t2_ready", 64'(rdy[0]), 64'h5);
    @(posedge clk); #1 sv = 4'b0010;
    @(negedge clk);
    chk("t2_conflict", 64'(cf[0]), 64'h1);
    chk("t2_waddr", 64'(wa[0]), 64'({5'd6, 5'd5}));
    chk("t2_ready_retry", 64'(rdy[0]), 64'h2);
    @(posedge clk); #1 sv = 4'b0000;

    // write to x0 with and without the sink
    @(posedge clk); #1 sv = 4'b1000; sa[19:15] = 5'd0;
    @(negedge clk);
    chk("t3_ready_z", 64'(rdy[0][3]), 64'h1);
    chk("t3_ready_n", 64'(rdy[1][3]), 64'h1);
    @(posedge clk); #1 sv = 4'b0000;
    @(negedge clk);
    chk("t3_waddr_z", 64'(wa[0][4:0]), 64'h0);
    chk("t3_we_z", 64'(we[0]), 64'h0);
    chk("t3_we_n", 64'(we[1]), 64'h1);

    // fairness over 8 saturated cycles
    sa = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int s = 0; s < 4; s++) cnt[s] = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1 sv = 4'b1111;
      @(negedge clk);
      for (int s = 0; s < 4; s++) cnt[s] += int'(rdy[0][s]);
    end
    for (int s = 0; s < 4; s++) chk($sformatf("t4_grants_src%0d", s), 64'(cnt[s]), 64'd4);
    @(posedge clk); #1 sv = 4'b0000;

    // flush with three valid sources after moving the pointer off 0
    @(posedge clk); #1 sv = 4'b0001; sa[4:0] = 5'd1;
    @(posedge clk); #1 sv = 4'b0111; sa = {5'd0, 5'd9, 5'd8, 5'd7}; flush = 1'b1;
    @(negedge clk); chk("t5_ready_flush", 64'(rdy[0]), 64'h0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("t5_we_after", 64'(we[0]), 64'h0);
    chk("t5_conf_after", 64'(cf[0]), 64'h0);
    chk("t5_ready_resume", 64'(rdy[0]), 64'h3);

    // asynchronous reset while both ports are writing
    @(posedge clk); #1 sv = 4'b0000;
    chk("t6_we_before", 64'(we[0]), 64'h3);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_we_async_z", 64'(we[0]), 64'h0);
    chk("t6_we_async_n", 64'(we[1]), 64'h0);
    chk("t6_conf_async", 64'(cf[0]), 64'h0);
    @(posedge clk); #1 rst_ni = 1'b1;

    // randomized traffic; sources hold their offer until it transfers on dut_z
    got = '0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 4; s++) begin
        if (got[s] || !sv[s]) begin
          sv[s] = ($urandom_range(2) != 0);
          sa[s*5 +: 5] = 5'($urandom_range(7));
          sd[s*32 +: 32] = $urandom;
        end
      end
      flush = ($urandom_range(15) == 0);
      @(negedge clk);
      got = flush ? 4'b0000 : rdy[0];
    end
    @(posedge clk); #1 sv = 4'b0000; flush = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter that shares the integer register file's write ports among multiple result producers (ALU, multiplier, load unit, CSR, etc.). Each source offers one register write per cycle over a valid/ready handshake. The block grants up to NR_WB_PORTS writes per cycle in round-robin order, never granting two writes to the same register in one cycle. Granted writes are registered and driven onto the regfile's waddr/wdata/we port vectors one cycle later.

## Interface
Parameters:
- DATA_WIDTH, 32, register data width
- NR_SRC, 4, number of writeback sources (2..8)
- NR_WB_PORTS, 2, number of regfile write ports (1..NR_SRC)
- ZERO_REG_ZERO, 1, if 1, writes to x0 are accepted and dropped (we_o stays 0)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- flush_i  in  1  blocks all grants this cycle; clears the output stage and round-robin pointer
- src_valid_i  in  NR_SRC  source s offers a write
- src_waddr_i  in  NR_SRC*5  destination register of source s, slice [s*5+:5]
- src_wdata_i  in  NR_SRC*DATA_WIDTH  write data of source s
- src_ready_o  out  NR_SRC  grant; a transfer occurs when valid && ready
- waddr_o  out  NR_WB_PORTS*5  regfile write address per port
- wdata_o  out  NR_WB_PORTS*DATA_WIDTH  regfile write data per port
- we_o  out  NR_WB_PORTS  regfile write enable per port
- conflict_o  out  1  registered pulse: a valid source lost only because of a same-address conflict

## Operation
- State:
  - rr_q, $clog2(NR_SRC) bits: highest-priority source index.
  - Output registers waddr_q, wdata_q, we_q.
  - conflict_q.
- Grant logic (combinational, per cycle):
  - Scan sources circularly from rr_q: rr_q, rr_q+1, … wrapping mod NR_SRC.
  - A source is eligible when src_valid_i=1 and its waddr differs from every waddr already granted this cycle.
  - Exception: if ZERO_REG_ZERO=1, waddr 0 never conflicts.
  - The first NR_WB_PORTS eligible sources are granted, in scan order. The k-th grant (k=0..) is assigned to write port k.
  - src_ready_o[s] = granted[s].
- Handshake:
  - Ready depends combinationally on valid. Sources must not make valid depend on ready.
  - A source keeps valid/waddr/wdata stable until the transfer.
  - Ready is never asserted while valid is 0.
- Output stage: on each clock edge, for each port k:
  - If a grant is assigned to k: waddr_q[k] and wdata_q[k] load from that source; we_q[k] = !(ZERO_REG_ZERO && waddr==0).
  - Otherwise: we_q[k]=0, and waddr/wdata hold their previous values.
- Pointer:
  - If at least one grant: rr_q <= (index of last granted source + 1) mod NR_SRC.
  - If no grant: rr_q holds.
- Conflict flag: conflict_q <= 1 when some valid, ungranted source was blocked only by an address match while a port was still free.
- Flush (flush_i=1):
  - src_ready_o is all 0.
  - Next cycle: we_o all 0, rr_q=0, conflict_o=0.
  - Flush overrides any grant in the same cycle.
- Fairness: a continuously valid source with no address conflicts is granted within ceil(NR_SRC/NR_WB_PORTS) cycles.

## Timing
- Reset values:
  - we_o=0, waddr_o=0, wdata_o=0, conflict_o=0, rr_q=0.
  - src_ready_o=0, since no valid is seen during reset.
- Latency: a transfer in cycle t appears on waddr_o/wdata_o/we_o in cycle t+1. The regfile commits it on edge t+2. Throughput is up to NR_WB_PORTS writes per cycle.
- Reset asserted mid-operation:
  - Outputs clear immediately (asynchronous).
  - Transfers already handshaken but not yet written are lost; upstream flushes with reset.
- Wrap-around: the scan from rr_q=NR_SRC-1 continues at source 0.
- Simultaneous same-address requests: only the higher-priority source (earlier in scan order) is granted. The other waits at least one cycle.

## Test plan
- Reset, then src_valid_i=4'b1111 with waddr 1,2,3,4 (NR_SRC=4, NR_WB_PORTS=2) ->
  - cycle 0 grants src0→port0 and src1→port1; rr_q=2.
  - cycle 1 grants src2 and src3; rr_q=0.
  - outputs appear one cycle after each grant with we_o=2'b11.
- src0 and src1 both valid with waddr=5, src2 valid with waddr=6, rr_q=0 ->
  - ready=3'b101; port0 gets waddr 5, port1 gets waddr 6; conflict_o=1 next cycle.
  - following cycle src1 is granted.
- src3 valid with waddr=0, ZERO_REG_ZERO=1 -> ready[3]=1, output waddr 0 with we_o=0; with ZERO_REG_ZERO=0 -> we_o=1.
- All sources held valid (distinct addresses) for 8 cycles -> every source granted exactly 4 times; no source waits more than 2 cycles.
- flush_i pulsed while 3 sources are valid -> src_ready_o=0 that cycle; next cycle we_o=0 and rr_q=0; grants resume from src0.
- rst_ni dropped asynchronously mid-cycle with we_o=2'b11 -> we_o=0 and conflict_o=0 immediately, before the next clock edge.
